// File: rtl/mem_arbiter.sv
// mem_arbiter
// Sequencer and round-robin arbiter in front of the SHA-256 memory manager.
// After reset it starts the ROM-to-RAM constant copy and waits for the
// memory manager to report completion (or times out). It then shares the
// single RAM port between three requesters with one transaction outstanding:
// 0 = message scheduler, 1 = compression round unit, 2 = host loader.
//
// Ports
//   CLK, RST_N        clock, synchronous active-low reset
//   RECOPY            pulse, re-run the ROM copy (honoured only in IDLE)
//   REQ/REQ_WE        per-requester request and write flag
//   REQ_ADDR          3 x 8-bit word addresses, requester i at [8i+7:8i]
//   REQ_WDATA         3 x 32-bit write words, requester i at [32i+31:32i]
//   GNT               one-hot pulse, request accepted
//   RVALID/RDATA      one-hot read-data pulse and the read word
//   INIT_DONE         copy phase finished (successfully or not)
//   INIT_ERR          sticky copy timeout flag
//   MM_*              memory manager interface (copy start/status, RE, WR,
//                     address, write data + bus drive enable, read data)
module mem_arbiter #(
    parameter int unsigned READ_LAT     = 1,
    parameter int unsigned COPY_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RECOPY,
    input  logic [2:0]  REQ,
    input  logic [2:0]  REQ_WE,
    input  logic [23:0] REQ_ADDR,
    input  logic [95:0] REQ_WDATA,
    output logic [2:0]  GNT,
    output logic [2:0]  RVALID,
    output logic [31:0] RDATA,
    output logic        INIT_DONE,
    output logic        INIT_ERR,
    output logic        MM_COPY_ROM,
    input  logic        MM_COPY_DONE,
    output logic        MM_RE,
    output logic        MM_WR,
    output logic [7:0]  MM_ADDR,
    output logic [31:0] MM_DATA_OUT,
    output logic        MM_DATA_OE,
    input  logic [31:0] MM_DATA_IN
);

    typedef enum logic [2:0] {
        ST_COPY_REQ     = 3'd0,
        ST_COPY_WAIT_LO = 3'd1,
        ST_COPY_WAIT_HI = 3'd2,
        ST_IDLE         = 3'd3,
        ST_ACCESS       = 3'd4,
        ST_RESP         = 3'd5
    } state_t;

    // The wait counter starts at 0 on entry, so the abort fires on the
    // COPY_TIMEOUT-th wait cycle when the counter holds COPY_TIMEOUT-1.
    localparam logic [7:0] TIMEOUT_LAST = 8'(COPY_TIMEOUT - 1);
    localparam logic [3:0] LAT_LAST     = 4'(READ_LAT - 1);

    state_t      state_r;
    logic [1:0]  rr_r;
    logic [1:0]  idx_r;
    logic        we_r;
    logic [7:0]  tmo_cnt_r;
    logic [3:0]  lat_cnt_r;

    logic [2:0]  pick_s;
    logic        grant_valid_s;
    logic [1:0]  grant_idx_s;
    logic        sel_we_s;
    logic [7:0]  sel_addr_s;
    logic [31:0] sel_wdata_s;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        case (idx)
            2'd0:    rr_next = 2'd1;
            2'd1:    rr_next = 2'd2;
            default: rr_next = 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] idx_onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    idx_onehot = 3'b001;
            2'd1:    idx_onehot = 3'b010;
            2'd2:    idx_onehot = 3'b100;
            default: idx_onehot = 3'b000;
        endcase
    endfunction

    // Returns {valid, index}: first set request scanning upward from ptr, mod 3.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [1:0] cand;
        logic [2:0] pick;
        cand = ptr;
        pick = 3'b000;
        for (int k = 0; k < 3; k++) begin
            pick = (!pick[2] && req[cand]) ? {1'b1, cand} : pick;
            cand = rr_next(cand);
        end
        return pick;
    endfunction

    // Round-robin choice and selection of the winner's request fields.
    always_comb begin
        pick_s        = rr_pick(REQ, rr_r);
        grant_valid_s = pick_s[2];
        grant_idx_s   = pick_s[1:0];
        sel_we_s      = 1'b0;
        sel_addr_s    = 8'd0;
        sel_wdata_s   = 32'd0;
        case (grant_idx_s)
            2'd0: begin
                sel_we_s    = REQ_WE[0];
                sel_addr_s  = REQ_ADDR[7:0];
                sel_wdata_s = REQ_WDATA[31:0];
            end
            2'd1: begin
                sel_we_s    = REQ_WE[1];
                sel_addr_s  = REQ_ADDR[15:8];
                sel_wdata_s = REQ_WDATA[63:32];
            end
            2'd2: begin
                sel_we_s    = REQ_WE[2];
                sel_addr_s  = REQ_ADDR[23:16];
                sel_wdata_s = REQ_WDATA[95:64];
            end
            default: begin
                sel_we_s    = 1'b0;
                sel_addr_s  = 8'd0;
                sel_wdata_s = 32'd0;
            end
        endcase
    end

    // Sequencer FSM with registered outputs; GNT, RVALID and MM_COPY_ROM are single-cycle pulses.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r     <= ST_COPY_REQ;
            rr_r        <= 2'd0;
            idx_r       <= 2'd0;
            we_r        <= 1'b0;
            tmo_cnt_r   <= 8'd0;
            lat_cnt_r   <= 4'd0;
            GNT         <= 3'b000;
            RVALID      <= 3'b000;
            RDATA       <= 32'd0;
            INIT_DONE   <= 1'b0;
            INIT_ERR    <= 1'b0;
            MM_COPY_ROM <= 1'b0;
            MM_RE       <= 1'b0;
            MM_WR       <= 1'b0;
            MM_ADDR     <= 8'd0;
            MM_DATA_OUT <= 32'd0;
            MM_DATA_OE  <= 1'b0;
        end else begin
            GNT         <= 3'b000;
            RVALID      <= 3'b000;
            MM_COPY_ROM <= 1'b0;
            case (state_r)
                ST_COPY_REQ: begin
                    MM_COPY_ROM <= 1'b1;
                    INIT_DONE   <= 1'b0;
                    tmo_cnt_r   <= 8'd0;
                    state_r     <= ST_COPY_WAIT_LO;
                end
                ST_COPY_WAIT_LO: begin
                    tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    if (!MM_COPY_DONE) begin
                        state_r <= ST_COPY_WAIT_HI;
                    end else if (tmo_cnt_r >= TIMEOUT_LAST) begin
                        INIT_ERR  <= 1'b1;
                        INIT_DONE <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r <= ST_COPY_WAIT_LO;
                    end
                end
                ST_COPY_WAIT_HI: begin
                    tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    if (MM_COPY_DONE) begin
                        INIT_DONE <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else if (tmo_cnt_r >= TIMEOUT_LAST) begin
                        INIT_ERR  <= 1'b1;
                        INIT_DONE <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r <= ST_COPY_WAIT_HI;
                    end
                end
                ST_IDLE: begin
                    if (RECOPY) begin
                        INIT_DONE <= 1'b0;
                        state_r   <= ST_COPY_REQ;
                    end else if (grant_valid_s) begin
                        // Access strobes rise together with GNT so a write
                        // frees the port after two cycles.
                        GNT       <= idx_onehot(grant_idx_s);
                        idx_r     <= grant_idx_s;
                        rr_r      <= rr_next(grant_idx_s);
                        we_r      <= sel_we_s;
                        lat_cnt_r <= 4'd0;
                        MM_ADDR   <= sel_addr_s;
                        if (sel_we_s) begin
                            MM_WR       <= 1'b1;
                            MM_DATA_OE  <= 1'b1;
                            MM_DATA_OUT <= sel_wdata_s;
                        end else begin
                            MM_RE <= 1'b1;
                        end
                        state_r <= ST_ACCESS;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (we_r) begin
                        MM_WR      <= 1'b0;
                        MM_DATA_OE <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else if (lat_cnt_r == LAT_LAST) begin
                        RDATA   <= MM_DATA_IN;
                        MM_RE   <= 1'b0;
                        state_r <= ST_RESP;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + 4'd1;
                    end
                end
                ST_RESP: begin
                    RVALID  <= idx_onehot(idx_r);
                    state_r <= ST_IDLE;
                end
                default: begin
                    MM_RE      <= 1'b0;
                    MM_WR      <= 1'b0;
                    MM_DATA_OE <= 1'b0;
                    state_r    <= ST_COPY_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios for the copy
// handshake, timeout, recopy and reset, plus a randomized request phase
// checked against a transaction-level model with its own memory image.
module tb_mem_arbiter;

    localparam int READ_LAT     = 1;
    localparam int COPY_TIMEOUT = 255;

    logic        CLK;
    logic        RST_N;
    logic        RECOPY;
    logic [2:0]  REQ;
    logic [2:0]  REQ_WE;
    logic [23:0] REQ_ADDR;
    logic [95:0] REQ_WDATA;
    logic [2:0]  GNT;
    logic [2:0]  RVALID;
    logic [31:0] RDATA;
    logic        INIT_DONE;
    logic        INIT_ERR;
    logic        MM_COPY_ROM;
    logic        MM_COPY_DONE;
    logic        MM_RE;
    logic        MM_WR;
    logic [7:0]  MM_ADDR;
    logic [31:0] MM_DATA_OUT;
    logic        MM_DATA_OE;
    logic [31:0] MM_DATA_IN;

    logic        r_we    [3];
    logic [7:0]  r_addr  [3];
    logic [31:0] r_wdata [3];

    logic [31:0] mm_mem  [256] = '{default: 32'd0};
    logic [31:0] ref_mem [256];

    logic [83:0] out_vec;
    int          rom_cnt = 0;
    int          total_cnt = 0;
    int          bad_cnt = 0;

    mem_arbiter #(.READ_LAT(READ_LAT), .COPY_TIMEOUT(COPY_TIMEOUT)) dut (
        .CLK(CLK), .RST_N(RST_N), .RECOPY(RECOPY), .REQ(REQ), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .GNT(GNT), .RVALID(RVALID),
        .RDATA(RDATA), .INIT_DONE(INIT_DONE), .INIT_ERR(INIT_ERR),
        .MM_COPY_ROM(MM_COPY_ROM), .MM_COPY_DONE(MM_COPY_DONE), .MM_RE(MM_RE),
        .MM_WR(MM_WR), .MM_ADDR(MM_ADDR), .MM_DATA_OUT(MM_DATA_OUT),
        .MM_DATA_OE(MM_DATA_OE), .MM_DATA_IN(MM_DATA_IN)
    );

    assign REQ_WE    = {r_we[2], r_we[1], r_we[0]};
    assign REQ_ADDR  = {r_addr[2], r_addr[1], r_addr[0]};
    assign REQ_WDATA = {r_wdata[2], r_wdata[1], r_wdata[0]};
    assign out_vec   = {GNT, RVALID, RDATA, INIT_DONE, INIT_ERR, MM_COPY_ROM,
                        MM_RE, MM_WR, MM_ADDR, MM_DATA_OUT, MM_DATA_OE};

    // RAM behind the memory manager: asynchronous read, write taken while MM_WR is high.
    assign MM_DATA_IN = mm_mem[MM_ADDR];

    initial CLK = 1'b0;
    // Free-running clock.
    always #5 CLK = ~CLK;

    // Memory write port and copy-start pulse counter, sampled on the falling edge.
    always @(negedge CLK) begin
        if (MM_WR === 1'b1) mm_mem[MM_ADDR] <= MM_DATA_OUT;
        if (MM_COPY_ROM === 1'b1) rom_cnt <= rom_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int oh_to_idx(input logic [2:0] v);
        case (v)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 7;
        endcase
    endfunction

    task automatic wait_rom();
        int k;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (MM_COPY_ROM !== 1'b1 && k < 20);
        check_val("rom_pulse", 96'(MM_COPY_ROM), 96'd1);
    endtask

    task automatic wait_gnt();
        int k;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (GNT === 3'b000 && k < 10);
    endtask

    // Reset, then play the memory manager: copy busy for lo_cycles, then done.
    task automatic do_init(input int lo_cycles);
        int rom_base;
        RST_N = 1'b0; REQ = 3'b000; RECOPY = 1'b0; MM_COPY_DONE = 1'b1;
        repeat (3) @(negedge CLK);
        check_val("reset_outputs", 96'(out_vec), 96'd0);
        rom_base = rom_cnt;
        RST_N = 1'b1;
        wait_rom();
        MM_COPY_DONE = 1'b0;
        repeat (lo_cycles) @(negedge CLK);
        MM_COPY_DONE = 1'b1;
        check_val("init_done_low", 96'(INIT_DONE), 96'd0);
        @(negedge CLK);
        check_val("init_done_rise", 96'(INIT_DONE), 96'd1);
        check_val("init_err_clear", 96'(INIT_ERR), 96'd0);
        check_val("rom_pulse_count", 96'(rom_cnt - rom_base), 96'd1);
    endtask

    // Randomized requests against a transaction-level model: the port is
    // free at a known cycle, the winner is the first pending requester from
    // the pointer, writes land in ref_mem and reads return its contents.
    task automatic run_random(input int ncyc);
        int          free_cyc, rr_m, gi, rv_cyc, rv_idx;
        logic        rv_pend;
        logic [31:0] rv_data;
        logic [2:0]  req_edge, exp_gnt, exp_rv;
        for (int a = 0; a < 256; a++) ref_mem[a] = mm_mem[a];
        free_cyc = 0; rr_m = 0; rv_pend = 1'b0; rv_cyc = 0; rv_idx = 0; rv_data = 32'd0;
        req_edge = REQ;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge CLK);
            exp_gnt = 3'b000;
            gi = -1;
            if (n >= free_cyc) begin
                for (int k = 0; k < 3; k++) begin
                    if (gi < 0 && req_edge[(rr_m + k) % 3]) gi = (rr_m + k) % 3;
                end
            end
            if (gi >= 0) exp_gnt[gi] = 1'b1;
            check_val("rnd_gnt", 96'(GNT), 96'(exp_gnt));
            if (gi >= 0) begin
                check_val("rnd_addr", 96'(MM_ADDR), 96'(r_addr[gi]));
                if (r_we[gi]) begin
                    check_val("rnd_wr", 96'({MM_WR, MM_DATA_OE, MM_RE}), 96'(3'b110));
                    check_val("rnd_wdata", 96'(MM_DATA_OUT), 96'(r_wdata[gi]));
                    ref_mem[r_addr[gi]] = r_wdata[gi];
                    free_cyc = n + 2;
                end else begin
                    check_val("rnd_rd", 96'({MM_WR, MM_DATA_OE, MM_RE}), 96'(3'b001));
                    rv_pend = 1'b1;
                    rv_cyc  = n + READ_LAT + 1;
                    rv_idx  = gi;
                    rv_data = ref_mem[r_addr[gi]];
                    free_cyc = n + READ_LAT + 2;
                end
                rr_m = (gi + 1) % 3;
                REQ[gi] = 1'b0;
            end
            exp_rv = 3'b000;
            if (rv_pend && rv_cyc == n) begin
                exp_rv[rv_idx] = 1'b1;
                rv_pend = 1'b0;
                check_val("rnd_rdata", 96'(RDATA), 96'(rv_data));
            end
            check_val("rnd_rvalid", 96'(RVALID), 96'(exp_rv));
            check_val("rnd_re_wr_excl", 96'(MM_RE & MM_WR), 96'd0);
            for (int i = 0; i < 3; i++) begin
                if (!REQ[i] && n < ncyc - 12 && $urandom_range(0, 2) == 0) begin
                    r_we[i]    = 1'($urandom_range(0, 1));
                    r_addr[i]  = 8'($urandom_range(0, 15));
                    r_wdata[i] = $urandom;
                    REQ[i]     = 1'b1;
                end
            end
            req_edge = REQ;
        end
        REQ = 3'b000;
    endtask

    initial begin
        int   got_ord [6];
        int   cnt, k;
        logic early, rv_seen;

        RST_N = 1'b0; RECOPY = 1'b0; REQ = 3'b000; MM_COPY_DONE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r_we[i] = 1'b0; r_addr[i] = 8'd0; r_wdata[i] = 32'd0;
        end

        // Copy handshake with a 72-cycle busy window.
        do_init(72);

        // Host loader writes then reads back 0x40.
        r_we[2] = 1'b1; r_addr[2] = 8'h40; r_wdata[2] = 32'hDEADBEEF; REQ = 3'b100;
        wait_gnt();
        check_val("wr_gnt", 96'(GNT), 96'(3'b100));
        check_val("wr_strobes", 96'({MM_WR, MM_DATA_OE, MM_RE}), 96'(3'b110));
        check_val("wr_addr", 96'(MM_ADDR), 96'h40);
        check_val("wr_data", 96'(MM_DATA_OUT), 96'hDEADBEEF);
        REQ = 3'b000;
        @(negedge CLK);
        check_val("wr_one_cycle", 96'({MM_WR, MM_DATA_OE}), 96'd0);
        r_we[2] = 1'b0; REQ = 3'b100;
        wait_gnt();
        check_val("rd_gnt", 96'(GNT), 96'(3'b100));
        check_val("rd_re", 96'({MM_RE, MM_WR}), 96'(2'b10));
        check_val("rd_addr", 96'(MM_ADDR), 96'h40);
        REQ = 3'b000;
        @(negedge CLK);
        check_val("rd_rvalid_early", 96'(RVALID), 96'd0);
        @(negedge CLK);
        check_val("rd_rvalid", 96'(RVALID), 96'(3'b100));
        check_val("rd_rdata", 96'(RDATA), 96'hDEADBEEF);
        @(negedge CLK);
        check_val("rd_rvalid_pulse", 96'(RVALID), 96'd0);

        // All three requesting continuously: fair rotation.
        for (int i = 0; i < 3; i++) begin
            r_we[i] = 1'b1; r_addr[i] = 8'(8'h80 + i); r_wdata[i] = $urandom;
        end
        for (int i = 0; i < 6; i++) got_ord[i] = 7;
        REQ = 3'b111;
        cnt = 0; k = 0;
        while (cnt < 6 && k < 40) begin
            @(negedge CLK);
            k++;
            if (GNT !== 3'b000) begin
                got_ord[cnt] = oh_to_idx(GNT);
                cnt++;
            end
        end
        REQ = 3'b000;
        for (int i = 0; i < 6; i++) check_val("rr_order", 96'(got_ord[i]), 96'(i % 3));

        // Randomized traffic from a fresh start.
        do_init(20);
        run_random(400);

        // Copy never completes: timeout, and no grant before it.
        RST_N = 1'b0; REQ = 3'b000; RECOPY = 1'b0; MM_COPY_DONE = 1'b1;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        wait_rom();
        r_we[0] = 1'b1; r_addr[0] = 8'h10; r_wdata[0] = 32'h12345678; REQ = 3'b001;
        k = 0; early = 1'b0;
        do begin
            @(negedge CLK);
            k++;
            if (GNT !== 3'b000) early = 1'b1;
        end while (INIT_DONE !== 1'b1 && k < 300);
        check_val("timeout_cycles", 96'(k), 96'(COPY_TIMEOUT));
        check_val("timeout_err", 96'(INIT_ERR), 96'd1);
        check_val("timeout_no_early_gnt", 96'(early), 96'd0);
        @(negedge CLK);
        check_val("timeout_then_gnt", 96'(GNT), 96'(3'b001));
        REQ = 3'b000;
        repeat (3) @(negedge CLK);

        // RECOPY beats a simultaneous request; INIT_ERR survives.
        r_we[0] = 1'b0; r_addr[0] = 8'h10; RECOPY = 1'b1; REQ = 3'b001;
        @(negedge CLK);
        RECOPY = 1'b0;
        check_val("recopy_no_gnt", 96'(GNT), 96'd0);
        check_val("recopy_done_drop", 96'(INIT_DONE), 96'd0);
        wait_rom();
        MM_COPY_DONE = 1'b0;
        early = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            if (GNT !== 3'b000) early = 1'b1;
        end
        MM_COPY_DONE = 1'b1;
        @(negedge CLK);
        check_val("recopy_done", 96'(INIT_DONE), 96'd1);
        check_val("recopy_err_kept", 96'(INIT_ERR), 96'd1);
        check_val("recopy_no_early_gnt", 96'({early, GNT}), 96'd0);
        @(negedge CLK);
        check_val("recopy_gnt", 96'(GNT), 96'(3'b001));
        REQ = 3'b000;
        @(negedge CLK);
        @(negedge CLK);
        check_val("recopy_rvalid", 96'(RVALID), 96'(3'b001));
        check_val("recopy_rdata", 96'(RDATA), 96'h12345678);
        repeat (2) @(negedge CLK);

        // Reset lands during a read access.
        r_we[1] = 1'b0; r_addr[1] = 8'h40; REQ = 3'b010;
        wait_gnt();
        check_val("mid_rd_gnt", 96'(GNT), 96'(3'b010));
        check_val("mid_rd_re", 96'(MM_RE), 96'd1);
        RST_N = 1'b0; REQ = 3'b000;
        @(negedge CLK);
        check_val("mid_rd_reset_outputs", 96'(out_vec), 96'd0);
        rv_seen = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (RVALID !== 3'b000) rv_seen = 1'b1;
        end
        RST_N = 1'b1;
        wait_rom();
        check_val("mid_rd_no_rvalid", 96'(rv_seen), 96'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequencer and arbiter in front of the SHA-256 memory manager: 32-bit data, 8-bit word address, ROM-to-RAM constant copy.
- After reset it issues the ROM copy (K constants plus initial H words) and waits for completion.
- It then shares the single RAM port round-robin between three requesters: 0 = message scheduler, 1 = compression round unit, 2 = host loader.
- One transaction is outstanding at a time.

Parameters:
- READ_LAT, default 1: cycles MM_RE is held before MM_DATA_IN is sampled (1..15).
- COPY_TIMEOUT, default 255: maximum cycles spent in either copy-wait state before abort (8-bit counter).

Ports:
- CLK  in  1  single system clock; all state changes on posedge.
- RST_N  in  1  synchronous active-low reset, sampled on posedge CLK.
- RECOPY  in  1  pulse: re-run the ROM copy (accepted only in IDLE).
- REQ  in  3  per-requester access request, held until GNT.
- REQ_WE  in  3  per-requester 1 = write, 0 = read.
- REQ_ADDR  in  24  three packed 8-bit word addresses; requester i uses bits [8i+7:8i].
- REQ_WDATA  in  96  three packed 32-bit write words; requester i uses bits [32i+31:32i].
- GNT  out  3  one-hot, one-cycle pulse: request accepted.
- RVALID  out  3  one-hot, one-cycle pulse: read data valid.
- RDATA  out  32  read data; valid only while RVALID is high.
- INIT_DONE  out  1  high once the copy phase has ended, successfully or not.
- INIT_ERR  out  1  sticky copy-timeout flag.
- MM_COPY_ROM  out  1  copy start to the memory manager.
- MM_COPY_DONE  in  1  copy-complete/idle status from the memory manager.
- MM_RE  out  1  memory manager read enable.
- MM_WR  out  1  memory manager write enable.
- MM_ADDR  out  8  memory manager word address.
- MM_DATA_OUT  out  32  write data; the top level drives the inout DATA bus with it when MM_DATA_OE = 1.
- MM_DATA_OE  out  1  DATA bus drive enable.
- MM_DATA_IN  in  32  DATA bus as seen by the arbiter.

Behaviour:
- Reset (RST_N = 0 at posedge):
  - State COPY_REQ.
  - All outputs 0; RR pointer = 0; timeout counter = 0; INIT_ERR cleared.
  - Reset mid-operation abandons any transaction: no GNT or RVALID is issued for it.
- COPY_REQ:
  - MM_COPY_ROM = 1 for exactly one cycle; INIT_DONE = 0.
  - Next state COPY_WAIT_LO.
- COPY_WAIT_LO:
  - Wait for MM_COPY_DONE = 0 (copy has started), then go to COPY_WAIT_HI.
- COPY_WAIT_HI:
  - Wait for MM_COPY_DONE = 1, then go to IDLE and set INIT_DONE = 1 on that transition.
- Timeout:
  - Counter cleared on entry to COPY_WAIT_LO; it increments every cycle in either wait state.
  - When it reaches COPY_TIMEOUT: INIT_ERR = 1 (sticky), INIT_DONE = 1, go to IDLE.
- No GNT is ever issued while INIT_DONE = 0.
- IDLE:
  - RECOPY = 1 takes precedence over all REQ: go to COPY_REQ and drop INIT_DONE. INIT_ERR is kept and cleared only by reset.
  - Otherwise, if any REQ bit is set, grant the first set bit scanning from the RR pointer upward, mod 3.
  - In the grant cycle: GNT[i] = 1, latch REQ_WE[i] / REQ_ADDR[i] / REQ_WDATA[i], RR pointer = (i+1) mod 3.
  - Next state ACCESS.
- ACCESS (write):
  - One cycle with MM_WR = 1, MM_DATA_OE = 1, MM_ADDR and MM_DATA_OUT = latched values.
  - Then back to IDLE; a write occupies 2 cycles from GNT to next grant.
- ACCESS (read):
  - MM_RE = 1, MM_ADDR = latched address, held for READ_LAT cycles.
  - In the last such cycle MM_DATA_IN is registered into RDATA.
  - Next cycle: RVALID[i] = 1 for one cycle, then IDLE.
  - Read occupancy = READ_LAT + 2 cycles.
- Outside ACCESS: MM_RE = MM_WR = MM_DATA_OE = 0, MM_ADDR holds its last value.
- MM_RE and MM_WR are never high together; neither is high during the copy states.
- RECOPY outside IDLE is ignored; it is not queued.
- REQ deasserted before GNT is simply not granted; there is no error.

Test Plan:
1. Reset, then model MM_COPY_DONE: 1 → 0 for 72 cycles → 1 -> exactly one MM_COPY_ROM pulse; INIT_DONE rises 1 cycle after MM_COPY_DONE returns to 1; INIT_ERR = 0.
2. Hold MM_COPY_DONE = 1 after reset, COPY_TIMEOUT = 255 -> INIT_ERR = 1 and INIT_DONE = 1 after 255 wait cycles; REQ asserted during the wait gets no GNT before that point.
3. Requester 2 writes 0xDEADBEEF to 0x40, then requester 2 reads 0x40 (READ_LAT = 1, memory model) -> MM_WR for 1 cycle with MM_ADDR = 0x40; RVALID[2] with RDATA = 0xDEADBEEF 2 cycles after the read GNT.
4. REQ = 3'b111 held continuously -> grant order 0,1,2,0,1,2; no requester is granted twice before the others are served.
5. RECOPY and REQ[0] both asserted in IDLE -> MM_COPY_ROM pulses; GNT[0] only after INIT_DONE is high again; INIT_ERR unchanged.
6. RST_N low during a read's ACCESS cycle -> no RVALID; all outputs 0; a fresh MM_COPY_ROM pulse after release.
